// File: rtl/jelly_wishbone_cmd_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// jelly_wishbone_cmd_sequencer : Wishbone master running a ROM command list
// Revision: 1.0
// ============================================================================

module jelly_wishbone_cmd_sequencer #(
  parameter int WB_ADR_WIDTH   = 30,
  parameter int WB_DAT_WIDTH   = 32,
  parameter int WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
  parameter int CMD_ADDR_WIDTH = 8,
  parameter int CMD_WIDTH      = 4 + WB_SEL_WIDTH + WB_ADR_WIDTH + WB_DAT_WIDTH,
  parameter int POLL_INTERVAL  = 64,
  parameter int POLL_TIMEOUT   = 4096
) (
  input  logic                      wb_rst_i,
  input  logic                      wb_clk_i,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [WB_DAT_WIDTH-1:0]   last_rdata,
  output logic [CMD_ADDR_WIDTH-1:0] cmd_index,
  output logic [CMD_ADDR_WIDTH-1:0] cmd_rd_adr,
  input  logic [CMD_WIDTH-1:0]      cmd_rd_dat,
  output logic [WB_ADR_WIDTH-1:0]   m_wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0]   m_wb_dat_o,
  input  logic [WB_DAT_WIDTH-1:0]   m_wb_dat_i,
  output logic                      m_wb_we_o,
  output logic [WB_SEL_WIDTH-1:0]   m_wb_sel_o,
  output logic                      m_wb_stb_o,
  input  logic                      m_wb_ack_i
);

  localparam int PCW = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT + 1) : 1;

  localparam logic [3:0] c_OP_END   = 4'd0;
  localparam logic [3:0] c_OP_WRITE = 4'd1;
  localparam logic [3:0] c_OP_READ  = 4'd2;
  localparam logic [3:0] c_OP_POLL  = 4'd3;
  localparam logic [3:0] c_OP_WAIT  = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_BUS      = 3'd3,
    S_WAIT     = 3'd4,
    S_POLL_GAP = 3'd5,
    S_DONE     = 3'd6,
    S_ERR      = 3'd7
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [CMD_ADDR_WIDTH-1:0] r_cmd_index;
  logic [3:0]                r_op;
  logic [WB_ADR_WIDTH-1:0]   r_adr;
  logic [WB_DAT_WIDTH-1:0]   r_dat;
  logic                      r_we;
  logic [WB_SEL_WIDTH-1:0]   r_sel;
  logic [WB_DAT_WIDTH-1:0]   r_cnt;
  logic [WB_DAT_WIDTH-1:0]   r_last_rdata;
  logic [PCW-1:0]            r_poll_cnt;
  logic                      r_error;
  logic                      r_abort_pend;

  logic [3:0]                w_op;
  logic [WB_SEL_WIDTH-1:0]   w_cmd_sel;
  logic [WB_ADR_WIDTH-1:0]   w_cmd_adr;
  logic [WB_DAT_WIDTH-1:0]   w_cmd_dat;
  logic                      w_bus_op;
  logic                      w_last;
  logic                      w_poll_match;
  logic [PCW-1:0]            w_poll_reads;
  logic                      w_poll_expired;
  logic                      w_advance;

  assign w_op           = cmd_rd_dat[CMD_WIDTH-1 -: 4];
  assign w_cmd_sel      = cmd_rd_dat[WB_ADR_WIDTH+WB_DAT_WIDTH +: WB_SEL_WIDTH];
  assign w_cmd_adr      = cmd_rd_dat[WB_DAT_WIDTH +: WB_ADR_WIDTH];
  assign w_cmd_dat      = cmd_rd_dat[WB_DAT_WIDTH-1:0];
  assign w_bus_op       = (w_op == c_OP_WRITE) || (w_op == c_OP_READ) || (w_op == c_OP_POLL);
  assign w_last         = &r_cmd_index;
  // POLL keeps its compare value in r_dat; it is never driven as write data (we=0)
  assign w_poll_match   = (m_wb_dat_i == r_dat);
  assign w_poll_reads   = r_poll_cnt + PCW'(1);
  assign w_poll_expired = (POLL_TIMEOUT != 0) && (w_poll_reads == PCW'(POLL_TIMEOUT));

  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    case (r_state)
      S_IDLE:     if (start) w_state_next = S_FETCH;
      S_FETCH:    w_state_next = abort ? S_IDLE : S_DECODE;
      S_DECODE: begin
        if (abort)                  w_state_next = S_IDLE;
        else if (w_op == c_OP_END)  w_state_next = S_DONE;
        else if (w_bus_op)          w_state_next = S_BUS;
        else if (w_op == c_OP_WAIT) w_state_next = S_WAIT;
        else                        w_state_next = S_ERR;
      end
      S_BUS: begin
        if (m_wb_ack_i) begin
          if (abort || r_abort_pend)                 w_state_next = S_IDLE;
          else if (r_op == c_OP_POLL && !w_poll_match) w_state_next = w_poll_expired ? S_ERR : S_POLL_GAP;
          else                                       w_advance = 1'b1;
        end
      end
      S_WAIT: begin
        if (abort)           w_state_next = S_IDLE;
        else if (r_cnt == '0) w_advance = 1'b1;
      end
      S_POLL_GAP: begin
        if (abort)           w_state_next = S_IDLE;
        else if (r_cnt == '0) w_state_next = S_BUS;
      end
      default:    w_state_next = S_IDLE;
    endcase
    // the last ROM entry never wraps back to 0
    if (w_advance) w_state_next = w_last ? S_DONE : S_FETCH;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) r_state <= S_IDLE;
    else           r_state <= w_state_next;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_cmd_index  <= '0;
      r_op         <= '0;
      r_adr        <= '0;
      r_dat        <= '0;
      r_we         <= 1'b0;
      r_sel        <= '0;
      r_cnt        <= '0;
      r_last_rdata <= '0;
      r_poll_cnt   <= '0;
      r_error      <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      if (w_state_next == S_ERR) r_error <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cmd_index  <= '0;
            r_error      <= 1'b0;
            r_abort_pend <= 1'b0;
          end
        end
        S_DECODE: begin
          r_op       <= w_op;
          r_poll_cnt <= '0;
          r_cnt      <= (w_cmd_dat == '0) ? '0 : w_cmd_dat - 1'b1;
          if (w_bus_op) begin
            r_adr <= w_cmd_adr;
            r_dat <= w_cmd_dat;
            r_we  <= (w_op == c_OP_WRITE);
            r_sel <= (w_op == c_OP_WRITE) ? w_cmd_sel : '1;
          end
        end
        S_BUS: begin
          // an abort during a transfer is remembered until the ack arrives
          if (abort) r_abort_pend <= 1'b1;
          if (m_wb_ack_i) begin
            r_abort_pend <= 1'b0;
            if (!r_we) r_last_rdata <= m_wb_dat_i;
            r_poll_cnt <= w_poll_reads;
            r_cnt      <= WB_DAT_WIDTH'(POLL_INTERVAL - 1);
          end
        end
        S_WAIT, S_POLL_GAP: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
      if (w_advance && !w_last) r_cmd_index <= r_cmd_index + 1'b1;
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign error      = r_error;
  assign last_rdata = r_last_rdata;
  assign cmd_index  = r_cmd_index;
  assign cmd_rd_adr = r_cmd_index;
  assign m_wb_adr_o = r_adr;
  assign m_wb_dat_o = r_dat;
  assign m_wb_we_o  = r_we;
  assign m_wb_sel_o = r_sel;
  assign m_wb_stb_o = (r_state == S_BUS);

endmodule

`default_nettype wire

// File: tb/tb_jelly_wishbone_cmd_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_jelly_wishbone_cmd_sequencer : ROM/slave models plus a command-list reference model
// Revision: 1.0
// ============================================================================

module tb_jelly_wishbone_cmd_sequencer;

  localparam int AW = 30, DW = 32, SW = 4, CAW = 8, CW = 4 + SW + AW + DW;
  localparam int PI = 64, PT = 4;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic          busy, done, error, we, stb, ack = 1'b0;
  logic [DW-1:0] last_rdata, dat_o, dat_i = '0;
  logic [CAW-1:0] cmd_index, cmd_rd_adr;
  logic [CW-1:0] cmd_rd_dat = '0;
  logic [AW-1:0] adr;
  logic [SW-1:0] sel;

  jelly_wishbone_cmd_sequencer #(
    .WB_ADR_WIDTH(AW), .WB_DAT_WIDTH(DW), .WB_SEL_WIDTH(SW), .CMD_ADDR_WIDTH(CAW),
    .CMD_WIDTH(CW), .POLL_INTERVAL(PI), .POLL_TIMEOUT(PT)
  ) u_dut (
    .wb_rst_i(rst_n), .wb_clk_i(clk), .start(start), .abort(abort),
    .busy(busy), .done(done), .error(error), .last_rdata(last_rdata),
    .cmd_index(cmd_index), .cmd_rd_adr(cmd_rd_adr), .cmd_rd_dat(cmd_rd_dat),
    .m_wb_adr_o(adr), .m_wb_dat_o(dat_o), .m_wb_dat_i(dat_i), .m_wb_we_o(we),
    .m_wb_sel_o(sel), .m_wb_stb_o(stb), .m_wb_ack_i(ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous command ROM
  logic [CW-1:0] rom [256];
  always @(posedge clk) cmd_rd_dat <= rom[cmd_rd_adr];

  // slave: ack after ack_lat wait cycles, read data from a list then rd_default
  int            ack_lat = 0, wcnt = 0, rd_ptr = 0, rd_end = 0;
  logic [DW-1:0] rd_arr [1024];
  logic [DW-1:0] rd_default = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack  <= 1'b0;
      wcnt <= 0;
    end else if (stb && !ack) begin
      if (wcnt >= ack_lat) begin
        ack  <= 1'b1;
        wcnt <= 0;
        if (!we) begin
          if (rd_ptr < rd_end) dat_i <= rd_arr[rd_ptr];
          else                 dat_i <= rd_default;
          rd_ptr <= rd_ptr + 1;
        end
      end else wcnt <= wcnt + 1;
    end else ack <= 1'b0;
  end

  typedef struct {
    logic [AW-1:0] adr; logic we; logic [DW-1:0] dat; logic [SW-1:0] sel; logic [DW-1:0] rd; int c;
  } txn_t;

  // bus monitor, sampled on the falling edge
  txn_t         mon[$];
  int           rise_c[$];
  int           done_cnt = 0, done_c = 0, hold_viol = 0, post_ack_viol = 0;
  logic         p_stb = 1'b0, p_fin = 1'b0;
  logic [66:0]  p_bus = '0;
  always @(negedge clk) begin
    if (stb && p_stb && !p_fin && ({adr, dat_o, we, sel} !== p_bus)) hold_viol <= hold_viol + 1;
    if (stb && p_fin) post_ack_viol <= post_ack_viol + 1;
    if (stb && !p_stb) rise_c.push_back(cyc);
    if (stb && ack) mon.push_back('{adr, we, dat_o, sel, dat_i, cyc});
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_c   <= cyc;
    end
    p_stb <= stb;
    p_fin <= stb && ack;
    p_bus <= {adr, dat_o, we, sel};
  end

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1);
  end

  // reference model: walks the command list by its rules, no cycle timing
  txn_t          exp_q[$];
  bit            exp_done, exp_err;
  int            exp_idx;
  logic [DW-1:0] m_last = '0;
  int            start_c = 0;

  task automatic model();
    int idx = 0, p = rd_ptr, n;
    bit stop = 0;
    logic [CW-1:0] c;
    logic [DW-1:0] rd;
    exp_q.delete(); exp_done = 0; exp_err = 0;
    while (!stop) begin
      c = rom[idx];
      case (c[CW-1 -: 4])
        4'd0: begin exp_done = 1; stop = 1; end
        4'd1: exp_q.push_back('{c[61:32], 1'b1, c[31:0], c[65:62], 32'h0, 0});
        4'd2: begin
          rd = (p < rd_end) ? rd_arr[p] : rd_default; p++;
          exp_q.push_back('{c[61:32], 1'b0, c[31:0], 4'hF, rd, 0}); m_last = rd;
        end
        4'd3: begin
          n = 0;
          do begin
            rd = (p < rd_end) ? rd_arr[p] : rd_default; p++; n++;
            exp_q.push_back('{c[61:32], 1'b0, c[31:0], 4'hF, rd, 0}); m_last = rd;
          end while (rd != c[31:0] && !(PT != 0 && n >= PT));
          if (rd != c[31:0]) begin exp_err = 1; stop = 1; end
        end
        4'd4: ;
        default: begin exp_err = 1; stop = 1; end
      endcase
      if (!stop) begin
        if (idx == 255) begin exp_done = 1; stop = 1; end
        else idx++;
      end
    end
    exp_idx = idx;
  endtask

  function automatic logic [CW-1:0] mk(logic [3:0] op, logic [3:0] s, logic [AW-1:0] a, logic [DW-1:0] d);
    return {op, s, a, d};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_idle_timeout"}, busy, 0);
  endtask

  task automatic run_checked(input string tag, input int lat, input bit with_abort);
    int mb, db;
    ack_lat = lat;
    model();
    mb = mon.size(); db = done_cnt;
    @(negedge clk); start = 1'b1; abort = with_abort; start_c = cyc;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    if (with_abort) chk({tag, "_start_wins"}, busy, 1);
    wait_idle(tag, 20000);
    chk({tag, "_ntx"}, mon.size() - mb, exp_q.size());
    for (int i = 0; i < exp_q.size() && mb + i < mon.size(); i++) begin
      chk($sformatf("%s_adr%0d", tag, i), mon[mb+i].adr, exp_q[i].adr);
      chk($sformatf("%s_we%0d", tag, i), mon[mb+i].we, exp_q[i].we);
      chk($sformatf("%s_sel%0d", tag, i), mon[mb+i].sel, exp_q[i].sel);
      if (exp_q[i].we) chk($sformatf("%s_dat%0d", tag, i), mon[mb+i].dat, exp_q[i].dat);
    end
    chk({tag, "_done"}, done_cnt - db, exp_done);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_last_rdata"}, last_rdata, m_last);
    chk({tag, "_cmd_index"}, cmd_index, exp_idx);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {busy, done, error, stb, we, sel, cmd_index, cmd_rd_adr}, 0);
    chk({tag, "_rdata"}, last_rdata, 0);
    chk({tag, "_bus"}, {adr, dat_o}, 0);
  endtask

  initial begin
    int mb, db, rb, n, len, kind, m;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    clear_rom();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_idle_noop", busy, 0);

    // 1: single write, late ack
    clear_rom();
    rom[0] = mk(4'd1, 4'hF, 30'h10004010, 32'd2048);
    rb = rise_c.size();
    run_checked("t1", 2, 0);
    chk("t1_first_stb_cycle", rise_c[rb] - start_c, 3);

    // 2: read
    clear_rom();
    rom[0] = mk(4'd2, 4'h0, 30'h10004000, 32'h0);
    rd_end = rd_ptr; rd_arr[rd_end] = 32'h527A0000; rd_end++;
    run_checked("t2", 1, 0);

    // 3: poll 1,1,0 then advance
    clear_rom();
    rom[0] = mk(4'd3, 4'h0, 30'h10008405, 32'h0);
    rd_end = rd_ptr;
    rd_arr[rd_end] = 1; rd_arr[rd_end+1] = 1; rd_arr[rd_end+2] = 0; rd_end += 3;
    mb = mon.size(); rb = rise_c.size();
    run_checked("t3", 0, 0);
    for (int i = 0; i < 2; i++)
      if (rb + i + 1 < rise_c.size() && mb + i < mon.size())
        chk($sformatf("t3_gap%0d_ge_interval", i), (rise_c[rb+i+1] - mon[mb+i].c - 1) >= PI, 1);

    // 4: poll timeout
    rd_end = rd_ptr; rd_default = 32'h1;
    run_checked("t4", 0, 0);

    // 5: abort while stb is held
    clear_rom();
    rom[0] = mk(4'd1, 4'hF, 30'h0AAAAAAA, 32'h11111111);
    rom[1] = mk(4'd1, 4'h3, 30'h05555555, 32'h22222222);
    ack_lat = 10; mb = mon.size(); db = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("t5_error_cleared", error, 0);
    n = 0;
    while (!stb && n < 20) begin @(negedge clk); n++; end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("t5_stb_held", stb, 1);
    wait_idle("t5", 100);
    chk("t5_ntx", mon.size() - mb, 1);
    if (mon.size() > mb) chk("t5_adr", mon[mb].adr, 30'h0AAAAAAA);
    chk("t5_no_done", done_cnt - db, 0);
    chk("t5_cmd_index", cmd_index, 0);
    run_checked("t5_rerun", 0, 1);

    // abort during WAIT
    clear_rom();
    rom[0] = mk(4'd4, 4'h0, 30'h0, 32'd40);
    db = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    chk("wabort_busy_before", busy, 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("wabort_busy_after", busy, 0);
    chk("wabort_no_done", done_cnt - db, 0);

    // 6a: reset in the middle of a WAIT
    clear_rom();
    rom[0] = mk(4'd2, 4'h0, 30'h12345678, 32'h0BADF00D);
    rom[1] = mk(4'd4, 4'h0, 30'h0, 32'd100);
    rd_end = rd_ptr; rd_arr[rd_end] = 32'hDEADBEEF; rd_end++;
    ack_lat = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_busy_in_wait", busy, 1);
    chk("t6_rdata_before", last_rdata, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    chk_zero("t6_async_reset");
    m_last = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 6b: 256 x WAIT 1 with no END
    for (int i = 0; i < 256; i++) rom[i] = mk(4'd4, 4'h0, 30'h0, 32'd1);
    run_checked("t6b", 0, 0);
    chk("t6b_done_cycle", done_c - start_c, 769);

    // randomized command lists
    for (int it = 0; it < 6; it++) begin
      clear_rom();
      rd_end = rd_ptr; rd_default = $urandom;
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        kind = $urandom_range(0, 19);
        a = AW'($urandom); d = $urandom;
        if (kind < 6) rom[j] = mk(4'd1, 4'($urandom_range(1, 15)), a, d);
        else if (kind < 10) begin
          rom[j] = mk(4'd2, 4'($urandom), a, d);
          rd_arr[rd_end] = $urandom; rd_end++;
        end else if (kind < 14) begin
          rom[j] = mk(4'd3, 4'($urandom), a, d);
          m = $urandom_range(0, 2);
          for (int k = 0; k < m; k++) begin rd_arr[rd_end] = ~d; rd_end++; end
          rd_arr[rd_end] = d; rd_end++;
        end else if (kind < 19) rom[j] = mk(4'd4, 4'h0, a, 32'($urandom_range(0, 5)));
        else rom[j] = mk(4'($urandom_range(5, 15)), 4'($urandom), a, d);
      end
      run_checked($sformatf("rnd%0d", it), $urandom_range(0, 3), 0);
    end

    @(negedge clk);
    chk("stb_hold_stable", hold_viol, 0);
    chk("stb_low_after_ack", post_ack_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
